hazard_control_unit: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the ID stage and drives the PC, IF/ID and ID/EX control enables. It resolves three conditions: load-use stalls, taken-branch flushes, and structural/data hazards against the multi-cycle multiply/divide unit (MDU), whose busy interval it tracks with an internal countdown. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_control_unit.sv | 122 ++++++++++++
 tb/tb_hazard_control_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Hazard controller for the 5-stage MIPS pipeline. It sits beside ID and
//   produces the PC / IF/ID / ID/EX enables and flushes. It resolves
//   load-use stalls, taken-branch flushes and hazards against the
//   multi-cycle MDU. The MDU busy window is tracked by an internal
//   countdown. A saturating stall counter is kept for performance debug.
//
// Ports
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   ID_Rs/ID_Rt     : source regs of the ID instruction; ID_UsesRt qualifies rt
//   ID_MduStart     : ID holds mult/multu/div/divu
//   ID_MduRead      : ID holds mfhi/mflo
//   ID_EX_MemRead   : EX holds a load writing ID_EX_Rt
//   EX_BranchTaken  : branch/jump resolved taken in EX
//   PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush : pipeline control
//   MduStart        : one-cycle issue strobe to the MDU
//   MduBusy         : registered, MDU countdown nonzero
//   StallCount      : saturating count of stall cycles
module hazard_control_unit #(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_MduStart,
  input  logic             ID_MduRead,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rt,
  input  logic             EX_BranchTaken,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MduStart,
  output logic             MduBusy,
  output logic [CNT_W-1:0] StallCount
);

  localparam int MW = $clog2(MDU_LATENCY + 1);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  state_t         state, state_nxt;
  logic [MW-1:0]  mdu_cnt, cnt_nxt;
  logic           load_use, mdu_haz, stall;

  assign MduBusy = (state == MDU_WAIT);

  // Hazard detection and pipeline control. Priority: reset, branch, stall.
  always_comb begin
    load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
               ((ID_EX_Rt == ID_Rs) || (ID_UsesRt && (ID_EX_Rt == ID_Rt)));
    mdu_haz  = MduBusy && (ID_MduRead || ID_MduStart);
    stall    = load_use || mdu_haz;

    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    MduStart    = 1'b0;

    if (rst) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (EX_BranchTaken) begin
      // The flush wins over any stall; the wrong-path MDU op is dropped.
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (stall) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end else begin
      MduStart    = ID_MduStart;
    end
  end

  // MDU countdown. MduStart can only fire in RUN, because in MDU_WAIT an
  // ID mult/div is a hazard and is held in ID. Branches do not touch the
  // countdown: the MDU op in flight is architecturally committed.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = mdu_cnt;
    case (state)
      RUN: begin
        if (MduStart) begin
          state_nxt = MDU_WAIT;
          cnt_nxt   = MW'(MDU_LATENCY);
        end
      end
      MDU_WAIT: begin
        cnt_nxt = mdu_cnt - MW'(1);
        if (mdu_cnt == MW'(1)) state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      mdu_cnt    <= '0;
      StallCount <= '0;
    end else begin
      state   <= state_nxt;
      mdu_cnt <= cnt_nxt;
      // One increment per stalled cycle, regardless of how many hazards
      // are active. Squashed cycles do not count. The counter saturates.
      if (stall && !EX_BranchTaken && (StallCount != {CNT_W{1'b1}}))
        StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  localparam int LAT   = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       ID_Rs, ID_Rt, ID_EX_Rt;
  logic             ID_UsesRt, ID_MduStart, ID_MduRead, ID_EX_MemRead, EX_BranchTaken;
  logic             PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MduStart, MduBusy;
  logic [CNT_W-1:0] StallCount;

  int errors = 0;
  int checks = 0;

  hazard_control_unit #(.MDU_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_MduStart(ID_MduStart), .ID_MduRead(ID_MduRead),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
    .EX_BranchTaken(EX_BranchTaken),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Flush(ID_EX_Flush), .MduStart(MduStart), .MduBusy(MduBusy),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; checks happen 1ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_EX_Rt = 5'd0;
    ID_UsesRt = 1'b0; ID_MduStart = 1'b0; ID_MduRead = 1'b0;
    ID_EX_MemRead = 1'b0; EX_BranchTaken = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); ID_MduStart = 1'b1;
    next_cycle(); #1;
    checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL rst_pcwrite got=%0b exp=0", PCWrite); end
    checks++; if (IF_ID_Write !== 1'b0) begin errors++; $display("FAIL rst_ifid_write got=%0b exp=0", IF_ID_Write); end
    checks++; if ({IF_ID_Flush, ID_EX_Flush} !== 2'b11) begin errors++; $display("FAIL rst_flush got=%b exp=11", {IF_ID_Flush, ID_EX_Flush}); end
    checks++; if (MduStart !== 1'b0) begin errors++; $display("FAIL rst_mdustart got=%0b exp=0", MduStart); end
    next_cycle(); rst = 1'b0; ID_MduStart = 1'b0; #1;
    checks++; if ({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b1100) begin errors++; $display("FAIL post_rst_ctrl got=%b exp=1100", {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}); end
    checks++; if (MduBusy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got=%0b exp=0", MduBusy); end
    checks++; if (StallCount !== 4'd0) begin errors++; $display("FAIL post_rst_cnt got=%0d exp=0", StallCount); end
  endtask

  task automatic test_load_use();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd5; ID_Rs = 5'd5; #1;
    checks++; if ({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b0001) begin errors++; $display("FAIL lu_ctrl got=%b exp=0001", {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}); end
    checks++; if (StallCount !== 4'd0) begin errors++; $display("FAIL lu_cnt0 got=%0d exp=0", StallCount); end
    next_cycle(); ID_EX_MemRead = 1'b0; #1;
    checks++; if ({PCWrite, ID_EX_Flush} !== 2'b10) begin errors++; $display("FAIL lu_release got=%b exp=10", {PCWrite, ID_EX_Flush}); end
    checks++; if (StallCount !== 4'd1) begin errors++; $display("FAIL lu_cnt1 got=%0d exp=1", StallCount); end
    // $zero destination never stalls
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd0; ID_Rs = 5'd0; #1;
    checks++; if ({PCWrite, ID_EX_Flush} !== 2'b10) begin errors++; $display("FAIL lu_r0 got=%b exp=10", {PCWrite, ID_EX_Flush}); end
    next_cycle(); idle(); #1;
    checks++; if (StallCount !== 4'd1) begin errors++; $display("FAIL lu_r0_cnt got=%0d exp=1", StallCount); end
  endtask

  task automatic test_rt_sense();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd7; ID_Rt = 5'd7; ID_Rs = 5'd3; ID_UsesRt = 1'b0; #1;
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL rt_unused got=%0b exp=1", PCWrite); end
    ID_UsesRt = 1'b1; #1;
    checks++; if ({PCWrite, IF_ID_Write, ID_EX_Flush} !== 3'b001) begin errors++; $display("FAIL rt_used got=%b exp=001", {PCWrite, IF_ID_Write, ID_EX_Flush}); end
    next_cycle(); idle(); #1;
    checks++; if (StallCount !== 4'd1) begin errors++; $display("FAIL rt_cnt got=%0d exp=1", StallCount); end
  endtask

  task automatic test_mdu_read();
    do_reset();
    ID_MduStart = 1'b1; #1;
    checks++; if ({MduStart, MduBusy} !== 2'b10) begin errors++; $display("FAIL mdu_issue got=%b exp=10", {MduStart, MduBusy}); end
    for (int c = 1; c <= LAT; c++) begin
      next_cycle(); ID_MduStart = 1'b0; ID_MduRead = 1'b1; #1;
      checks++; if ({MduBusy, PCWrite, IF_ID_Write, ID_EX_Flush} !== 4'b1001) begin errors++; $display("FAIL mdu_wait c%0d got=%b exp=1001", c, {MduBusy, PCWrite, IF_ID_Write, ID_EX_Flush}); end
    end
    next_cycle(); #1;
    checks++; if ({MduBusy, PCWrite, ID_EX_Flush} !== 3'b010) begin errors++; $display("FAIL mdu_done got=%b exp=010", {MduBusy, PCWrite, ID_EX_Flush}); end
    checks++; if (StallCount !== 4'd4) begin errors++; $display("FAIL mdu_cnt got=%0d exp=4", StallCount); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ID_MduStart = 1'b1;
    for (int c = 1; c <= LAT; c++) begin
      next_cycle(); #1;
      checks++; if ({MduStart, PCWrite} !== 2'b00) begin errors++; $display("FAIL b2b_hold c%0d got=%b exp=00", c, {MduStart, PCWrite}); end
    end
    next_cycle(); #1;
    checks++; if ({MduStart, MduBusy, PCWrite} !== 3'b101) begin errors++; $display("FAIL b2b_reissue got=%b exp=101", {MduStart, MduBusy, PCWrite}); end
    checks++; if (StallCount !== 4'd4) begin errors++; $display("FAIL b2b_cnt got=%0d exp=4", StallCount); end
    next_cycle(); ID_MduStart = 1'b0; #1;
    checks++; if (MduBusy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%0b exp=1", MduBusy); end
  endtask

  task automatic test_branch();
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd5; ID_Rs = 5'd5; ID_MduStart = 1'b1; EX_BranchTaken = 1'b1; #1;
    checks++; if ({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MduStart} !== 5'b11110) begin errors++; $display("FAIL br_ctrl got=%b exp=11110", {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MduStart}); end
    next_cycle(); idle(); #1;
    checks++; if ({MduBusy, StallCount} !== 5'b0_0000) begin errors++; $display("FAIL br_state got busy=%0b cnt=%0d exp busy=0 cnt=0", MduBusy, StallCount); end
    // flush during MDU_WAIT leaves the countdown running
    ID_MduStart = 1'b1;
    next_cycle(); ID_MduStart = 1'b0; ID_MduRead = 1'b1; EX_BranchTaken = 1'b1; #1;
    checks++; if ({MduBusy, PCWrite, IF_ID_Flush, ID_EX_Flush} !== 4'b1111) begin errors++; $display("FAIL br_wait got=%b exp=1111", {MduBusy, PCWrite, IF_ID_Flush, ID_EX_Flush}); end
    for (int c = 2; c <= LAT; c++) begin
      next_cycle(); idle(); #1;
      checks++; if (MduBusy !== 1'b1) begin errors++; $display("FAIL br_busy c%0d got=%0b exp=1", c, MduBusy); end
    end
    next_cycle(); #1;
    checks++; if ({MduBusy, StallCount} !== 5'b0_0000) begin errors++; $display("FAIL br_end got busy=%0b cnt=%0d exp busy=0 cnt=0", MduBusy, StallCount); end
  endtask

  task automatic test_dual_hazard();
    do_reset();
    ID_MduStart = 1'b1;
    next_cycle(); ID_MduStart = 1'b0; ID_MduRead = 1'b1;
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd9; ID_Rs = 5'd9;
    next_cycle(); idle(); #1;
    checks++; if (StallCount !== 4'd1) begin errors++; $display("FAIL dual_cnt got=%0d exp=1", StallCount); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ID_MduStart = 1'b1;
    next_cycle(); idle(); ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd4; ID_Rs = 5'd4;
    next_cycle(); idle(); rst = 1'b1; ID_MduStart = 1'b1; #1;
    checks++; if ({MduBusy, StallCount} !== 5'b1_0001) begin errors++; $display("FAIL rmid_pre got busy=%0b cnt=%0d exp busy=1 cnt=1", MduBusy, StallCount); end
    checks++; if ({PCWrite, IF_ID_Flush, MduStart} !== 3'b010) begin errors++; $display("FAIL rmid_ctrl got=%b exp=010", {PCWrite, IF_ID_Flush, MduStart}); end
    next_cycle(); rst = 1'b0; idle(); #1;
    checks++; if ({MduBusy, StallCount} !== 5'b0_0000) begin errors++; $display("FAIL rmid_post got busy=%0b cnt=%0d exp busy=0 cnt=0", MduBusy, StallCount); end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd2; ID_Rs = 5'd2;
    for (int i = 1; i <= (1 << CNT_W) + 3; i++) begin
      next_cycle(); #1;
      exp_cnt = (i > 15) ? 15 : i;
      checks++; if (StallCount !== exp_cnt[CNT_W-1:0]) begin errors++; $display("FAIL sat_cnt i%0d got=%0d exp=%0d", i, StallCount, exp_cnt); end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1; idle();
    test_reset();
    test_load_use();
    test_rt_sense();
    test_mdu_read();
    test_back_to_back();
    test_branch();
    test_dual_hazard();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
